// File: rtl/ir_remote_pkg.sv
// Shared constants and types for the IR key path: clocking figures, ingress FSM states
// and the buffered event layout {repeat, code}.
package ir_remote_pkg;

   localparam int unsigned KEY_W      = 8;
   localparam int unsigned CLK_HZ     = 304000;
   localparam int unsigned BIT_HZ     = 38000;
   localparam int unsigned OVERSAMPLE = CLK_HZ / BIT_HZ;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StHeld = 1'b1
   } ingress_state_e;

   typedef struct packed {
      logic             is_repeat;
      logic [KEY_W-1:0] code;
   } key_evt_t;

   function automatic key_evt_t make_evt(input logic rep, input logic [KEY_W-1:0] code);
      key_evt_t evt;
      evt.is_repeat = rep;
      evt.code      = code;
      return evt;
   endfunction

endpackage

// File: rtl/ir_key_dispatcher_if.sv
// Valid/ready event stream from the key dispatcher to application logic.
interface ir_key_dispatcher_if;
   import ir_remote_pkg::*;

   logic             valid;
   logic             ready;
   logic [KEY_W-1:0] code;
   logic             is_repeat;

   modport master (output valid, output code, output is_repeat, input ready);
   modport slave  (input valid, input code, input is_repeat, output ready);

endinterface

// File: rtl/ir_key_fifo.sv
// Small synchronous FIFO of key events; a push into a full FIFO succeeds only when a pop
// happens on the same cycle.
module ir_key_fifo
   import ir_remote_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  key_evt_t               push_data_i,
   input  logic                   pop_i,
   output key_evt_t               head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   key_evt_t        mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CntW'(DEPTH));
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      head_o  = mem_q[rd_ptr_q];
      count_o = count_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/ir_key_dispatcher.sv
// Turns decoded IR frames into press events, folds held-key re-transmissions, buffers them.
// Define IR_KEY_AUTOREPEAT_EN to emit a repeat event every REPEAT_COUNT same-code frames.
module ir_key_dispatcher
   import ir_remote_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned REPEAT_WINDOW = 30400,
   parameter int unsigned REPEAT_COUNT  = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        key_valid_i,
   input  logic [KEY_W-1:0]            key_code_i,
   ir_key_dispatcher_if.master         out_if,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
   output logic                        overflow_o,
   input  logic                        ovf_clear_i
);

   localparam int unsigned WinW = ($clog2(REPEAT_WINDOW) > 0) ? $clog2(REPEAT_WINDOW) : 1;
   localparam logic [WinW-1:0] WinMax = WinW'(REPEAT_WINDOW - 1);

   ingress_state_e   state_q, state_d;
   logic [KEY_W-1:0] last_code_q, last_code_d;
   logic [WinW-1:0]  win_q, win_d;
   logic             overflow_q, overflow_d;

   logic     push, pop, take_press, full, empty;
   key_evt_t push_evt, head;

`ifdef IR_KEY_AUTOREPEAT_EN
   localparam int unsigned RepW = ($clog2(REPEAT_COUNT) > 0) ? $clog2(REPEAT_COUNT) : 1;
   localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_COUNT - 1);
   logic [RepW-1:0] rep_q, rep_d;
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = ^REPEAT_COUNT;
`endif

   always_comb begin
      state_d     = state_q;
      last_code_d = last_code_q;
      win_d       = win_q;
      take_press  = 1'b0;
      push        = 1'b0;
      push_evt    = make_evt(1'b0, key_code_i);
`ifdef IR_KEY_AUTOREPEAT_EN
      rep_d       = rep_q;
`endif

      unique case (state_q)
         StIdle: take_press = key_valid_i;
         StHeld: begin
            // A frame arriving on the expiry cycle still counts as part of the hold.
            if (key_valid_i && key_code_i != last_code_q) begin
               take_press = 1'b1;
            end else if (key_valid_i) begin
               win_d = WinMax;
`ifdef IR_KEY_AUTOREPEAT_EN
               if (rep_q == RepMax) begin
                  push     = 1'b1;
                  push_evt = make_evt(1'b1, last_code_q);
                  rep_d    = '0;
               end else begin
                  rep_d = rep_q + RepW'(1);
               end
`endif
            end else if (win_q == '0) begin
               state_d = StIdle;
            end else begin
               win_d = win_q - WinW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (take_press) begin
         push        = 1'b1;
         push_evt    = make_evt(1'b0, key_code_i);
         last_code_d = key_code_i;
         win_d       = WinMax;
         state_d     = StHeld;
`ifdef IR_KEY_AUTOREPEAT_EN
         rep_d       = '0;
`endif
      end
   end

   ir_key_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push),
      .push_data_i(push_evt),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (fifo_count_o)
   );

   always_comb begin
      pop        = ~empty & out_if.ready;
      // A fresh drop beats a simultaneous clear.
      overflow_d = overflow_q;
      if (ovf_clear_i)         overflow_d = 1'b0;
      if (push & full & ~pop)  overflow_d = 1'b1;

      out_if.valid     = ~empty;
      out_if.code      = head.code;
`ifdef IR_KEY_AUTOREPEAT_EN
      out_if.is_repeat = head.is_repeat;
`else
      out_if.is_repeat = 1'b0;
`endif
      overflow_o = overflow_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         last_code_q <= '0;
         win_q       <= '0;
         overflow_q  <= 1'b0;
`ifdef IR_KEY_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_code_q <= last_code_d;
         win_q       <= win_d;
         overflow_q  <= overflow_d;
`ifdef IR_KEY_AUTOREPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

endmodule
